ddram_arbiter: RTL
==================

# ddram_arbiter

Shares the single toggle-handshake DDR3 port (`rd_req`/`rd_ack`, `we_req`/`we_ack`) between three requesters: the ROM download writer, the Genesis core ROM fetch, and battery save-RAM access. It sits between the requesters and `ddram`, with one transaction in flight at a time. Priority is fixed: download, then ROM, then SRAM. A deferral counter keeps SRAM from being starved by ROM traffic. Every upstream port uses the codebase toggle protocol: a request is pending while `req != ack`.

## Interface
Parameters:
- `SRAM_BASE`, 24'h800000, word address in DDR3 where save RAM word 0 lives.
- `SRAM_MAX_DEFER`, 4, number of ROM grants allowed while SRAM is pending before SRAM is forced through (1..15).

Ports:
- `MCLK`  in  1  system clock. All logic is in this domain.
- `RESET_N`  in  1  reset, synchronous, active-low.
- `ld_active`  in  1  download in progress. While high, ROM and SRAM requests stay pending and are not granted.
- `ld_req` in 1 / `ld_ack` out 1  download write toggle pair.
- `ld_addr`  in  24  download word address.
- `ld_din`  in  16  download write data.
- `rom_req` in 1 / `rom_ack` out 1  ROM read toggle pair.
- `rom_addr`  in  23  ROM word address.
- `rom_dout`  out  16  ROM read data. Valid when `rom_ack` toggles.
- `sram_req` in 1 / `sram_ack` out 1  save-RAM toggle pair.
- `sram_we`  in  1  1 = write, 0 = read. Sampled at grant.
- `sram_addr`  in  16  save-RAM word address.
- `sram_din`  in  16  save-RAM write data.
- `sram_dout`  out  16  save-RAM read data. Valid when `sram_ack` toggles. Unchanged on writes.
- `mem_addr`  out  24  word address to `ddram`.
- `mem_din`  out  16  write data to `ddram`.
- `mem_rd_req` out 1 / `mem_rd_ack` in 1  read toggle pair to `ddram`.
- `mem_we_req` out 1 / `mem_we_ack` in 1  write toggle pair to `ddram`.
- `mem_dout`  in  16  read data from `ddram`. Valid when `mem_rd_ack` equals `mem_rd_req`.

## Operation
- Pending flags, evaluated combinationally:
  - `ld_p = ld_req ^ ld_ack`
  - `rom_p = (rom_req ^ rom_ack) & ~ld_active`
  - `sram_p = (sram_req ^ sram_ack) & ~ld_active`
- FSM has two states: IDLE and WAIT.
- In IDLE, the winner is chosen in this order:
  1. `ld_p`.
  2. Otherwise `sram_p` if `defer_cnt == SRAM_MAX_DEFER`.
  3. Otherwise `rom_p`.
  4. Otherwise `sram_p`.
- On a grant:
  - Latch `mem_addr` and `mem_din`, record the owner, toggle the correct downstream request, and go to WAIT.
  - Download: `mem_addr = ld_addr`, write.
  - ROM: `mem_addr = {1'b0, rom_addr}`, read.
  - SRAM: `mem_addr = SRAM_BASE + sram_addr` (24-bit add, carry dropped), read or write per `sram_we`.
- `defer_cnt` (4 bits):
  - Increments, saturating at `SRAM_MAX_DEFER`, on every ROM grant made while `sram_p` = 1.
  - Clears on every SRAM grant.
  - Unchanged otherwise.
- In WAIT, the transaction completes when the used downstream pair matches (`mem_rd_ack == mem_rd_req` or `mem_we_ack == mem_we_req`). On that edge:
  - Register `mem_dout` into the owner's `_dout` (reads only).
  - Toggle the owner's `_ack`.
  - Go to IDLE.
- Requester inputs are not sampled in WAIT. A requester may change `addr`/`din` only after its ack toggles.
- A `ld_active` fall with no pending work causes no transaction.

## Timing
- Reset (`RESET_N` low at a rising edge): every output goes to 0 and stays 0 until the first edge with `RESET_N` high.
  - Outputs: all `_ack`, `mem_rd_req`, `mem_we_req`, `mem_addr`, `mem_din`, `rom_dout`, `sram_dout`.
  - Internal: state = IDLE, `defer_cnt` = 0.
- Reset mid-transaction abandons it without issuing an ack. `ddram` and the requesters must be reset in the same cycle so that all toggle pairs restart equal.
- Grant latency: a request seen pending in IDLE at edge N drives `mem_*_req` toggled after edge N.
- Completion: a downstream match sampled at edge M gives the port ack toggled and `_dout` updated after edge M.
- The earliest next grant is edge M+1. Back-to-back transactions are separated by exactly one IDLE cycle.
- Requests arriving while in WAIT remain pending and are arbitrated at the next IDLE. No request is ever lost or duplicated.
- Simultaneous new requests in the same IDLE cycle: exactly one is granted per the order above. The others are granted in subsequent IDLE cycles.

## Test plan
- Reset, then a ROM read at `rom_addr` = 23'h000010 with memory model returning 16'hBEEF after 5 cycles:
  - `mem_rd_req` toggles 1 cycle after the request, with `mem_addr` = 24'h000010.
  - `rom_dout` = 16'hBEEF and `rom_ack` toggles the cycle after `mem_rd_ack` matches.
- SRAM write with `sram_addr` = 16'h0003, `sram_din` = 16'h1234:
  - `mem_we_req` toggles with `mem_addr` = 24'h800003, `mem_din` = 16'h1234.
  - `sram_dout` stays unchanged.
- `ld_active` = 1 with ROM, SRAM and download requests all pending:
  - Only download writes are issued.
  - ROM and SRAM are granted, ROM first, in the IDLE cycles after `ld_active` falls.
- SRAM held pending while ROM requests arrive continuously, `SRAM_MAX_DEFER` = 4:
  - Exactly 4 ROM grants, then the SRAM grant, then `defer_cnt` = 0.
- `RESET_N` pulsed low during WAIT of a ROM read:
  - All outputs are 0 next cycle and no `rom_ack` toggle occurs.
  - A fresh request after reset completes normally.

Source files
------------

// File: rtl/ddram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ddram_arbiter_if
// Brief    : Requester-side and ddram-side toggle-handshake bundle for the
//            DDR3 port arbiter.
// Revision : 1.0
// ============================================================================
interface ddram_arbiter_if;
    logic        ld_active;
    logic        ld_req;
    logic        ld_ack;
    logic [23:0] ld_addr;
    logic [15:0] ld_din;

    logic        rom_req;
    logic        rom_ack;
    logic [22:0] rom_addr;
    logic [15:0] rom_dout;

    logic        sram_req;
    logic        sram_ack;
    logic        sram_we;
    logic [15:0] sram_addr;
    logic [15:0] sram_din;
    logic [15:0] sram_dout;

    logic [23:0] mem_addr;
    logic [15:0] mem_din;
    logic        mem_rd_req;
    logic        mem_rd_ack;
    logic        mem_we_req;
    logic        mem_we_ack;
    logic [15:0] mem_dout;

    // Arbiter side
    modport slave (
        input  ld_active, ld_req, ld_addr, ld_din,
        input  rom_req, rom_addr,
        input  sram_req, sram_we, sram_addr, sram_din,
        input  mem_rd_ack, mem_we_ack, mem_dout,
        output ld_ack, rom_ack, rom_dout, sram_ack, sram_dout,
        output mem_addr, mem_din, mem_rd_req, mem_we_req
    );

    // Requesters plus ddram side
    modport master (
        output ld_active, ld_req, ld_addr, ld_din,
        output rom_req, rom_addr,
        output sram_req, sram_we, sram_addr, sram_din,
        output mem_rd_ack, mem_we_ack, mem_dout,
        input  ld_ack, rom_ack, rom_dout, sram_ack, sram_dout,
        input  mem_addr, mem_din, mem_rd_req, mem_we_req
    );
endinterface
`default_nettype wire

// File: rtl/ddram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ddram_arbiter
// Brief    : Fixed-priority (download > ROM > SRAM) sharing of one toggle
//            DDR3 port, with a deferral limit that keeps SRAM from starving.
// Revision : 1.0
// ============================================================================
module ddram_arbiter #(
    parameter logic [23:0] SRAM_BASE      = 24'h800000,
    parameter int          SRAM_MAX_DEFER = 4
) (
    input  wire logic      MCLK,
    input  wire logic      RESET_N,
    ddram_arbiter_if.slave bus
);
    localparam logic [3:0] c_max_defer = 4'(SRAM_MAX_DEFER);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;
    typedef enum logic [1:0] {OWN_LD = 2'd0, OWN_ROM = 2'd1, OWN_SRAM = 2'd2} owner_t;

    state_t      state_q, state_d;
    owner_t      owner_q, owner_d;
    logic        is_wr_q, is_wr_d;
    logic [3:0]  defer_cnt_q, defer_cnt_d;
    logic [23:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_din_q, mem_din_d;
    logic        mem_rd_req_q, mem_rd_req_d;
    logic        mem_we_req_q, mem_we_req_d;
    logic        ld_ack_q, ld_ack_d;
    logic        rom_ack_q, rom_ack_d;
    logic        sram_ack_q, sram_ack_d;
    logic [15:0] rom_dout_q, rom_dout_d;
    logic [15:0] sram_dout_q, sram_dout_d;

    logic ld_p, rom_p, sram_p;
    logic grant_ld, grant_rom, grant_sram, sram_forced, done;

    assign ld_p   = bus.ld_req ^ ld_ack_q;
    assign rom_p  = (bus.rom_req ^ rom_ack_q) & ~bus.ld_active;
    assign sram_p = (bus.sram_req ^ sram_ack_q) & ~bus.ld_active;

    // Once ROM has won c_max_defer times over a waiting SRAM, SRAM outranks ROM.
    assign sram_forced = sram_p && (defer_cnt_q == c_max_defer);
    assign grant_ld    = ld_p;
    assign grant_rom   = !ld_p && !sram_forced && rom_p;
    assign grant_sram  = !ld_p && sram_p && !grant_rom;

    assign done = is_wr_q ? (bus.mem_we_ack == mem_we_req_q)
                          : (bus.mem_rd_ack == mem_rd_req_q);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        is_wr_d      = is_wr_q;
        defer_cnt_d  = defer_cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        mem_rd_req_d = mem_rd_req_q;
        mem_we_req_d = mem_we_req_q;
        ld_ack_d     = ld_ack_q;
        rom_ack_d    = rom_ack_q;
        sram_ack_d   = sram_ack_q;
        rom_dout_d   = rom_dout_q;
        sram_dout_d  = sram_dout_q;

        unique case (state_q)
            S_IDLE: begin
                if (grant_ld) begin
                    owner_d    = OWN_LD;
                    is_wr_d    = 1'b1;
                    mem_addr_d = bus.ld_addr;
                    mem_din_d  = bus.ld_din;
                end else if (grant_rom) begin
                    owner_d    = OWN_ROM;
                    is_wr_d    = 1'b0;
                    mem_addr_d = {1'b0, bus.rom_addr};
                    if (sram_p && (defer_cnt_q != c_max_defer))
                        defer_cnt_d = defer_cnt_q + 4'd1;
                end else if (grant_sram) begin
                    owner_d     = OWN_SRAM;
                    is_wr_d     = bus.sram_we;
                    mem_addr_d  = SRAM_BASE + {8'h00, bus.sram_addr};
                    mem_din_d   = bus.sram_din;
                    defer_cnt_d = 4'd0;
                end
                if (grant_ld || grant_rom || grant_sram) begin
                    state_d = S_WAIT;
                    if (is_wr_d) mem_we_req_d = ~mem_we_req_q;
                    else         mem_rd_req_d = ~mem_rd_req_q;
                end
            end
            S_WAIT: begin
                if (done) begin
                    state_d = S_IDLE;
                    unique case (owner_q)
                        OWN_LD:  ld_ack_d = ~ld_ack_q;
                        OWN_ROM: begin
                            rom_ack_d = ~rom_ack_q;
                            if (!is_wr_q) rom_dout_d = bus.mem_dout;
                        end
                        OWN_SRAM: begin
                            sram_ack_d = ~sram_ack_q;
                            if (!is_wr_q) sram_dout_d = bus.mem_dout;
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge MCLK) begin
        if (!RESET_N) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_LD;
            is_wr_q      <= 1'b0;
            defer_cnt_q  <= 4'd0;
            mem_addr_q   <= 24'd0;
            mem_din_q    <= 16'd0;
            mem_rd_req_q <= 1'b0;
            mem_we_req_q <= 1'b0;
            ld_ack_q     <= 1'b0;
            rom_ack_q    <= 1'b0;
            sram_ack_q   <= 1'b0;
            rom_dout_q   <= 16'd0;
            sram_dout_q  <= 16'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            is_wr_q      <= is_wr_d;
            defer_cnt_q  <= defer_cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            mem_rd_req_q <= mem_rd_req_d;
            mem_we_req_q <= mem_we_req_d;
            ld_ack_q     <= ld_ack_d;
            rom_ack_q    <= rom_ack_d;
            sram_ack_q   <= sram_ack_d;
            rom_dout_q   <= rom_dout_d;
            sram_dout_q  <= sram_dout_d;
        end
    end

    assign bus.ld_ack     = ld_ack_q;
    assign bus.rom_ack    = rom_ack_q;
    assign bus.sram_ack   = sram_ack_q;
    assign bus.rom_dout   = rom_dout_q;
    assign bus.sram_dout  = sram_dout_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_din    = mem_din_q;
    assign bus.mem_rd_req = mem_rd_req_q;
    assign bus.mem_we_req = mem_we_req_q;
endmodule
`default_nettype wire
